cbuf_write_arbiter: RTL

Shares one `circullar_buffer` write port between N_REQ producers using round-robin arbitration, with bounded-length burst grants. It also exposes the buffer read side as a valid/ready stream. The arbiter owns the buffer's `i_write_en` and `i_read_en`, so the buffer never reaches its overrun or underrun state in normal use. It sits between the CPLD's capture sources and the single drain consumer (the host-link serializer).

---
 rtl/cbuf_write_arbiter_pkg.sv | 19 +
 rtl/cbuf_write_arbiter_rr_pick.sv | 34 +++
 rtl/circullar_buffer.sv | 66 ++++++
 rtl/cbuf_write_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cbuf_write_arbiter_pkg.sv
// cbuf_write_arbiter_pkg
//   Shared types and helpers for the circular-buffer write arbiter.
//   state_t : arbiter FSM encoding (S_IDLE / S_BURST)
//   u_log2  : ceil(log2(v)), never less than 1, so counters stay at least 1 bit wide
package cbuf_write_arbiter_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    function automatic int u_log2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/cbuf_write_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector. Returns the first set bit of i_valid
//   searching upward from i_last+1, wrapping modulo N_REQ.
// Ports
//   i_valid  per-requester valid vector
//   i_last   index granted most recently
//   o_idx    selected index (0 when nothing is valid)
//   o_any    any bit of i_valid set
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [31:0] w_cand;

    // Walk the offsets from farthest to nearest, so the nearest valid
    // candidate is the last one assigned and therefore wins.
    always_comb begin
        o_idx  = '0;
        w_cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = (32'(i_last) + 32'(k)) % 32'(N_REQ);
            if (i_valid[w_cand[IDX_W-1:0]]) o_idx = w_cand[IDX_W-1:0];
        end
    end

    assign o_any = |i_valid;

endmodule

// File: rtl/circullar_buffer.sv
// circullar_buffer
//   Single-clock FIFO ring. Holds BUFFER_SIZE-1 words because one slot is
//   kept empty to tell full from empty. BUFFER_SIZE must be a power of two,
//   so the pointers wrap naturally.
// Ports
//   i_clk, i_rst_n       clock, async active-low reset (empties the ring)
//   i_write_en, i_data   push a word
//   i_read_en            pop the head word
//   o_data               head word, combinational (stale when empty)
//   o_level              occupancy
//   o_overrun            push on a full ring with no pop; the word is dropped
//   o_underrun           pop on an empty ring; the pointer does not move
module circullar_buffer
    import cbuf_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int BUFFER_SIZE = 256
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_write_en,
    input  logic                               i_read_en,
    input  logic [DATA_WIDTH-1:0]              i_data,
    output logic [DATA_WIDTH-1:0]              o_data,
    output logic [u_log2(BUFFER_SIZE)-1:0]     o_level,
    output logic                               o_overrun,
    output logic                               o_underrun
);

    localparam int AW = u_log2(BUFFER_SIZE);

    logic [DATA_WIDTH-1:0] r_mem [BUFFER_SIZE];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_do_wr;
    logic                  w_do_rd;

    assign o_level = r_wr_ptr - r_rd_ptr;
    assign w_full  = (o_level == AW'(BUFFER_SIZE - 1));
    assign w_empty = (o_level == '0);

    // A push on a full ring is accepted only when a pop frees a slot in
    // the same cycle.
    assign w_do_wr    = i_write_en & (~w_full | i_read_en);
    assign w_do_rd    = i_read_en & ~w_empty;
    assign o_overrun  = i_write_en & w_full & ~i_read_en;
    assign o_underrun = i_read_en & w_empty;
    assign o_data     = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/cbuf_write_arbiter.sv
// cbuf_write_arbiter
//   Round-robin arbiter that shares one circullar_buffer write port between
//   N_REQ producers. Each grant accepts at most MAX_BURST words. The buffer
//   read side is presented as a valid/ready stream. The arbiter drives both
//   buffer enables, so neither overrun nor underrun happens in normal use.
// Ports
//   i_clk, i_rst_n   clock, async active-low reset (also resets the buffer)
//   i_wr_valid       per-requester word valid
//   i_wr_data        requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_wr_ready       per-requester accept, at most one bit high
//   o_rd_valid       buffer non-empty
//   o_rd_data        buffer head word
//   i_rd_ready       consumer accept
//   o_level          buffer occupancy
//   o_grant          one-hot current grant, zero while idle
//   o_fault          sticky: the buffer saw an overrun or underrun
module cbuf_write_arbiter
    import cbuf_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int BUFFER_SIZE = 256,
    parameter int N_REQ       = 4,
    parameter int MAX_BURST   = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [N_REQ-1:0]                  i_wr_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]       i_wr_data,
    output logic [N_REQ-1:0]                  o_wr_ready,
    output logic                              o_rd_valid,
    output logic [DATA_WIDTH-1:0]             o_rd_data,
    input  logic                              i_rd_ready,
    output logic [u_log2(BUFFER_SIZE)-1:0]    o_level,
    output logic [N_REQ-1:0]                  o_grant,
    output logic                              o_fault
);

    localparam int BURST_W = u_log2(MAX_BURST);
    localparam int IDX_W   = u_log2(N_REQ);
    localparam int LVL_W   = u_log2(BUFFER_SIZE);

    state_t               r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_idx,   w_idx_nxt;
    logic [IDX_W-1:0]     r_last,  w_last_nxt;
    logic [BURST_W-1:0]   r_cnt,   w_cnt_nxt;
    logic                 r_fault;

    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_pick_any;
    logic [LVL_W-1:0]     w_level;
    logic                 w_rd_fire;
    logic                 w_wr_fire;
    logic                 w_full;
    logic                 w_in_burst;
    logic                 w_gnt_valid;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                 w_overrun;
    logic                 w_underrun;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_valid (i_wr_valid),
        .i_last  (r_last),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    circullar_buffer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BUFFER_SIZE (BUFFER_SIZE)
    ) u_buf (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_write_en (w_wr_fire),
        .i_read_en  (w_rd_fire),
        .i_data     (w_wr_data),
        .o_data     (o_rd_data),
        .o_level    (w_level),
        .o_overrun  (w_overrun),
        .o_underrun (w_underrun)
    );

    // Read only from a non-empty buffer: a pop on empty would return a
    // stale word even if a push lands in the same cycle.
    assign o_rd_valid = (w_level != '0);
    assign w_rd_fire  = o_rd_valid & i_rd_ready;
    assign o_level    = w_level;

    // A concurrent pop frees a slot, so a full buffer may still take a word.
    assign w_full      = (w_level == LVL_W'(BUFFER_SIZE - 1)) & ~w_rd_fire;
    assign w_in_burst  = (r_state == S_BURST);
    assign w_gnt_valid = i_wr_valid[r_idx];
    assign o_grant     = w_in_burst ? (N_REQ'(1) << r_idx) : '0;
    assign o_wr_ready  = o_grant & {N_REQ{~w_full}};
    assign w_wr_fire   = w_in_burst & w_gnt_valid & ~w_full;
    assign w_wr_data   = i_wr_data[r_idx*DATA_WIDTH +: DATA_WIDTH];
    assign o_fault     = r_fault;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_last  <= IDX_W'(N_REQ - 1);
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fault <= r_fault | w_overrun | w_underrun;
        end
    end

    // A burst also ends when the requester drops valid after its last word;
    // that is seen one cycle later as valid low, costing one dead cycle.
    // While full the grant holds with the count frozen.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pick_any) begin
                    w_idx_nxt   = w_pick_idx;
                    w_last_nxt  = w_pick_idx;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (!w_gnt_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (w_wr_fire) begin
                    if (r_cnt == BURST_W'(MAX_BURST - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
